operand_feeder: RTL
===================

OPERAND_FEEDER -- requirements
Module: operand_feeder

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, operand element width.
REQ-002 SHALL have parameter N, default 4, array side; one beat carries N A-elements and N B-elements.
REQ-003 SHALL have parameter COUNTER_BITS, default 16, width of len_input.
REQ-004 SHALL have parameter DEPTH, default 64, beats per bank; DEPTH < 2**COUNTER_BITS.
REQ-005 SHALL have port clk, input, 1, single clock; all logic on posedge.
REQ-006 SHALL have port reset, input, 1, synchronous, active-high.
REQ-007 SHALL have ports load_valid (input, 1) and load_ready (output, 1): load-side handshake.
REQ-008 SHALL have port load_last, input, 1, marks final beat of a job.
REQ-009 SHALL have ports load_a and load_b, input, [DATA_WIDTH-1:0] x N each: one A column and one B row.
REQ-010 SHALL have ports input_valid (output, 1) and input_ready (input, 1): array-side handshake.
REQ-011 SHALL have port len_input, output, COUNTER_BITS, beat count of the job being streamed.
REQ-012 SHALL have ports a_data and b_data, output, [DATA_WIDTH-1:0] x N each: streamed column/row.
REQ-013 SHALL have port busy, output, 1, high when any bank is non-empty.

Function
REQ-014 SHALL hold two banks; each has DEPTH entries, a count, and state EMPTY, FILLING or FULL.
REQ-015 SHALL keep wr_bank and rd_bank pointers; load writes go to wr_bank, streaming reads come from rd_bank.
REQ-016 SHALL drive load_ready = 1 when state[wr_bank] is EMPTY or FILLING.
REQ-017 SHALL, on a load beat (load_valid && load_ready), write entry count[wr_bank], increment the count, and move EMPTY to FILLING.
REQ-018 SHALL close the bank when an accepted beat has load_last=1 or brings the count to DEPTH: next state FULL, wr_bank toggles.
REQ-019 SHALL drive input_valid = 1 combinationally whenever state[rd_bank] == FULL, so the first beat is offered the cycle after the bank closes.
REQ-020 SHALL drive len_input = count[rd_bank] and hold it stable while input_valid=1; len_input = 0 otherwise.
REQ-021 SHALL drive a_data/b_data from entry rd_idx of rd_bank while input_valid=1, and all-zero otherwise.
REQ-022 SHALL advance rd_idx only on input_valid && input_ready; while input_ready=0, outputs hold unchanged.
REQ-023 SHALL, on the beat with rd_idx == count-1, return the bank to EMPTY, clear its count, zero rd_idx and toggle rd_bank.
REQ-024 SHALL deliver beats of one job in load order, and jobs in load order.
REQ-025 SHALL allow a load beat and a drain beat on different banks in the same cycle, including a close and a final drain together.
REQ-026 SHALL make a one-beat job (load_last on the first beat) produce len_input=1; zero-length jobs cannot occur.

Reset
REQ-027 SHALL, on reset, set both banks EMPTY, counts 0, wr_bank=rd_bank=0 and rd_idx=0.
REQ-028 SHALL hold outputs at load_ready=1, input_valid=0, len_input=0, a_data=b_data=0 and busy=0 from the cycle after reset.
REQ-029 SHALL discard in-progress jobs when reset is asserted mid-operation; bank storage itself is not reset.

Configuration
REQ-030 SHALL add output trunc_err (1 bit, sticky, cleared only by reset) when OPERAND_FEEDER_TRUNC_ERR_EN is defined; it sets when a bank closes at DEPTH without load_last.
REQ-031 SHALL, without OPERAND_FEEDER_TRUNC_ERR_EN, omit trunc_err; DEPTH auto-close still occurs silently.

Structure
REQ-032 SHALL place bank_state_e (EMPTY, FILLING, FULL) and default parameter constants in shared package mm_engine_pkg.
REQ-033 SHALL implement one sub-module, operand_bank, containing storage, count and state for a single bank, instantiated twice.

Verification
REQ-034 SHALL check reset: after reset, load_ready=1, input_valid=0, len_input=0, busy=0.
REQ-035 SHALL check a 3-beat job (last on beat 3) with input_ready=1: input_valid rises next cycle, len_input=3, the 3 beats match in order, then input_valid=0.
REQ-036 SHALL check ping-pong: with input_ready=0, load two 4-beat jobs, then load_ready=0 on a third; raise input_ready and confirm load_ready=1 the cycle after job 1's last beat.
REQ-037 SHALL check backpressure: toggle input_ready randomly during a 5-beat job; a_data, b_data and len_input stay stable while stalled and no beat is lost or duplicated.
REQ-038 SHALL check DEPTH=8 with 9 beats and no last: bank 0 streams len_input=8, the 9th beat lands in bank 1, and trunc_err=1 when the macro is enabled.
REQ-039 SHALL check reset asserted mid-drain of beat 2 of 4: the next cycle has input_valid=0 and busy=0, and a fresh job streams correctly.

Source files
------------

// File: rtl/mm_engine_pkg.sv
// Shared types and default sizing for the operand feeder and its banks.
package mm_engine_pkg;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FILLING = 2'd1,
    FULL    = 2'd2
  } bank_state_e;

  localparam int DEF_DATA_WIDTH   = 8;
  localparam int DEF_N            = 4;
  localparam int DEF_COUNTER_BITS = 16;
  localparam int DEF_DEPTH        = 64;

  // Index width for a bank of 'depth' entries; a 1-entry bank still needs 1 bit.
  function automatic int idx_bits(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/operand_bank.sv
// One operand bank: DEPTH beats of A-column/B-row storage, fill count and
// EMPTY/FILLING/FULL state. Writes append at 'count'; reads are asynchronous
// at the index supplied by the feeder.
module operand_bank
  import mm_engine_pkg::*;
#(
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int N            = DEF_N,
  parameter int COUNTER_BITS = DEF_COUNTER_BITS,
  parameter int DEPTH        = DEF_DEPTH,
  localparam int AW          = idx_bits(DEPTH)
)(
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             wr_en,
  input  logic                             wr_last,
  input  logic [N-1:0][DATA_WIDTH-1:0]     wr_a,
  input  logic [N-1:0][DATA_WIDTH-1:0]     wr_b,
  input  logic                             clr,
  input  logic [AW-1:0]                    rd_idx,
  output bank_state_e                      state,
  output logic [COUNTER_BITS-1:0]          count,
  output logic [N-1:0][DATA_WIDTH-1:0]     rd_a,
  output logic [N-1:0][DATA_WIDTH-1:0]     rd_b,
  output logic                             closing,
  output logic                             trunc
);

  localparam logic [COUNTER_BITS-1:0] DEPTH_C = COUNTER_BITS'(DEPTH);

  logic [N-1:0][DATA_WIDTH-1:0] mem_a [DEPTH];
  logic [N-1:0][DATA_WIDTH-1:0] mem_b [DEPTH];
  logic                         at_depth;

  // A write that fills the last slot closes the bank even without load_last.
  always_comb begin
    at_depth = ((count + 1'b1) == DEPTH_C);
    closing  = wr_en && (wr_last || at_depth);
    trunc    = wr_en && !wr_last && at_depth;
  end

  // Fill/drain bookkeeping; a bank is never written and cleared in one cycle
  // because writes need EMPTY/FILLING and clears need FULL.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= EMPTY;
      count <= '0;
    end else if (clr) begin
      state <= EMPTY;
      count <= '0;
    end else if (wr_en) begin
      count <= count + 1'b1;
      state <= closing ? FULL : FILLING;
    end
  end

  // Operand storage is left unreset; the state/count make stale data invisible.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_a[count[AW-1:0]] <= wr_a;
      mem_b[count[AW-1:0]] <= wr_b;
    end
  end

  // Asynchronous read port for the streaming side.
  always_comb begin
    rd_a = mem_a[rd_idx];
    rd_b = mem_b[rd_idx];
  end

endmodule

// File: rtl/operand_feeder.sv
// Double-buffered operand feeder: jobs are loaded into one bank while the
// other streams to the array. Optional sticky trunc_err output is built when
// OPERAND_FEEDER_TRUNC_ERR_EN is defined.
module operand_feeder
  import mm_engine_pkg::*;
#(
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int N            = DEF_N,
  parameter int COUNTER_BITS = DEF_COUNTER_BITS,
  parameter int DEPTH        = DEF_DEPTH
)(
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             load_valid,
  output logic                             load_ready,
  input  logic                             load_last,
  input  logic [N-1:0][DATA_WIDTH-1:0]     load_a,
  input  logic [N-1:0][DATA_WIDTH-1:0]     load_b,
  output logic                             input_valid,
  input  logic                             input_ready,
  output logic [COUNTER_BITS-1:0]          len_input,
  output logic [N-1:0][DATA_WIDTH-1:0]     a_data,
  output logic [N-1:0][DATA_WIDTH-1:0]     b_data,
`ifdef OPERAND_FEEDER_TRUNC_ERR_EN
  output logic                             trunc_err,
`endif
  output logic                             busy
);

  localparam int AW = idx_bits(DEPTH);

  bank_state_e                  st  [2];
  logic [COUNTER_BITS-1:0]      cnt [2];
  logic [N-1:0][DATA_WIDTH-1:0] ra  [2];
  logic [N-1:0][DATA_WIDTH-1:0] rb  [2];
  logic [1:0]                   closing;
  logic [1:0]                   trunc;

  logic                         wr_bank;
  logic                         rd_bank;
  logic [AW-1:0]                rd_idx;
  logic                         ld;
  logic                         drain;
  logic                         last_drain;
  logic [COUNTER_BITS-1:0]      rd_cnt;

  for (genvar g = 0; g < 2; g++) begin : g_bank
    operand_bank #(
      .DATA_WIDTH   (DATA_WIDTH),
      .N            (N),
      .COUNTER_BITS (COUNTER_BITS),
      .DEPTH        (DEPTH)
    ) u_bank (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (ld && (wr_bank == 1'(g))),
      .wr_last (load_last),
      .wr_a    (load_a),
      .wr_b    (load_b),
      .clr     (last_drain && (rd_bank == 1'(g))),
      .rd_idx  (rd_idx),
      .state   (st[g]),
      .count   (cnt[g]),
      .rd_a    (ra[g]),
      .rd_b    (rb[g]),
      .closing (closing[g]),
      .trunc   (trunc[g])
    );
  end

  // Handshakes and output muxing; everything offered comes from rd_bank and
  // is zeroed while that bank is not FULL.
  always_comb begin
    load_ready  = (st[wr_bank] != FULL);
    ld          = load_valid && load_ready;
    input_valid = (st[rd_bank] == FULL);
    drain       = input_valid && input_ready;
    rd_cnt      = cnt[rd_bank];
    last_drain  = drain && (COUNTER_BITS'(rd_idx) == (rd_cnt - 1'b1));
    len_input   = input_valid ? rd_cnt : '0;
    a_data      = input_valid ? ra[rd_bank] : '0;
    b_data      = input_valid ? rb[rd_bank] : '0;
    busy        = (st[0] != EMPTY) || (st[1] != EMPTY);
  end

  // Load side moves to the other bank once the current one closes.
  always_ff @(posedge clk) begin
    if (reset)
      wr_bank <= 1'b0;
    else if (ld && |closing)
      wr_bank <= ~wr_bank;
  end

  // Stream side walks rd_idx through the FULL bank, then hands it back.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_bank <= 1'b0;
      rd_idx  <= '0;
    end else if (last_drain) begin
      rd_bank <= ~rd_bank;
      rd_idx  <= '0;
    end else if (drain) begin
      rd_idx  <= rd_idx + 1'b1;
    end
  end

`ifdef OPERAND_FEEDER_TRUNC_ERR_EN
  // Sticky flag: a job was cut at DEPTH without its last beat.
  always_ff @(posedge clk) begin
    if (reset)
      trunc_err <= 1'b0;
    else if (|trunc)
      trunc_err <= 1'b1;
  end
`else
  logic unused_trunc;
  assign unused_trunc = ^trunc;
`endif

endmodule
